id_hazard_tracker: RTL and testbench

- Parametrised operand hazard and bypass unit for the decode stage.
- Tracks in-flight register writers in a shift-register of pipeline slots (EX, MEM, WB, ...).
- Resolves every source operand of the instruction in ID to either the regfile or the youngest in-flight producer.
- Raises a stall when the producer's result is not yet available. Supports per-instruction result latency, pipeline hold, branch flush, and a stall performance counter.

---
 rtl/id_hazard_tracker.sv | 138 +++++++++++++
 tb/tb_id_hazard_tracker.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_tracker.sv
// Decode-stage operand hazard/bypass unit. Tracks in-flight writers in an
// age-ordered slot shift register and resolves each ID source operand to the
// regfile or the youngest in-flight producer, stalling when it isn't ready.

// Per-source lookup: youngest matching producer, its bypass data and hazard.
module id_hazard_lookup #(
  parameter int XLEN   = 32,
  parameter int NSTAGE = 3,
  parameter int AGE_W  = 2
) (
  input  logic [4:0]                    src_idx,
  input  logic                          src_used,
  input  logic [XLEN-1:0]               rf_data,
  input  logic [NSTAGE*XLEN-1:0]        byp_data,
  input  logic [NSTAGE:1]               slot_vld,
  input  logic [NSTAGE:1][4:0]          slot_rd,
  input  logic [NSTAGE:1][AGE_W-1:0]    slot_rdy,
  output logic [AGE_W-1:0]              fwd_sel,
  output logic [XLEN-1:0]               op_data,
  output logic                          hazard
);
  // Scan oldest to youngest so the youngest match is written last and wins.
  always_comb begin
    fwd_sel = '0;
    op_data = rf_data;
    hazard  = 1'b0;
    if (src_used && src_idx != 5'd0) begin
      for (int k = NSTAGE; k >= 1; k--) begin
        if (slot_vld[k] && slot_rd[k] == src_idx) begin
          fwd_sel = AGE_W'(k);
          op_data = byp_data[(k-1)*XLEN +: XLEN];
          hazard  = (AGE_W'(k) < slot_rdy[k]);
        end
      end
    end
  end
endmodule

module id_hazard_tracker #(
  parameter int XLEN      = 32,
  parameter int NSRC      = 2,
  parameter int NSTAGE    = 3,
  parameter int AGE_W     = 2,
  parameter int FLUSH_AGE = 0,
  parameter int CNT_W     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_valid,
  input  logic                     issue_wr,
  input  logic [4:0]               issue_rd,
  input  logic [AGE_W-1:0]         issue_lat,
  input  logic [NSRC*5-1:0]        src_idx,
  input  logic [NSRC-1:0]          src_used,
  input  logic [NSRC*XLEN-1:0]     rf_data,
  input  logic [NSTAGE*XLEN-1:0]   byp_data,
  input  logic                     hold,
  input  logic                     flush,
  output logic                     stall,
  output logic                     issue_ack,
  output logic [NSRC*AGE_W-1:0]    fwd_sel,
  output logic [NSRC*XLEN-1:0]     op_data,
  output logic [CNT_W-1:0]         stall_cnt
);
  logic [NSTAGE:1]             vld_q, vld_d;
  logic [NSTAGE:1][4:0]        rd_q, rd_d;
  logic [NSTAGE:1][AGE_W-1:0]  rdy_q, rdy_d;
  logic [CNT_W-1:0]            stall_cnt_q, stall_cnt_d;
  logic [NSRC-1:0]             haz;

  // One lookup lane per source operand.
  for (genvar s = 0; s < NSRC; s++) begin : g_src
    id_hazard_lookup #(.XLEN(XLEN), .NSTAGE(NSTAGE), .AGE_W(AGE_W)) u_lkp (
      .src_idx  (src_idx[s*5 +: 5]),
      .src_used (src_used[s]),
      .rf_data  (rf_data[s*XLEN +: XLEN]),
      .byp_data (byp_data),
      .slot_vld (vld_q),
      .slot_rd  (rd_q),
      .slot_rdy (rdy_q),
      .fwd_sel  (fwd_sel[s*AGE_W +: AGE_W]),
      .op_data  (op_data[s*XLEN +: XLEN]),
      .hazard   (haz[s])
    );
  end

  assign stall     = |haz;
  assign issue_ack = issue_valid & ~stall & ~hold & ~flush;
  assign stall_cnt = stall_cnt_q;

  // Slot update: shift and issue unless held; flush squashes young slots.
  always_comb begin
    vld_d = vld_q;
    rd_d  = rd_q;
    rdy_d = rdy_q;
    if (!hold) begin
      for (int k = NSTAGE; k >= 2; k--) begin
        vld_d[k] = vld_q[k-1];
        rd_d[k]  = rd_q[k-1];
        rdy_d[k] = rdy_q[k-1];
      end
      // A stalled or flushed ID instruction enters as a bubble.
      vld_d[1] = issue_ack & issue_wr & (issue_rd != 5'd0);
      rd_d[1]  = issue_rd;
      rdy_d[1] = (issue_lat == '0) ? AGE_W'(1) : issue_lat;
      if (flush) begin
        // Pre-shift age k now sits at k+1.
        for (int k = 1; k < NSTAGE; k++)
          if (k <= FLUSH_AGE) vld_d[k+1] = 1'b0;
      end
    end else if (flush) begin
      for (int k = 1; k <= NSTAGE; k++)
        if (k <= FLUSH_AGE) vld_d[k] = 1'b0;
    end
  end

  // Saturating count of cycles where a valid ID instruction is hazard-stalled.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (issue_valid && stall && !hold && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q       <= '0;
      rd_q        <= '0;
      rdy_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      vld_q       <= vld_d;
      rd_q        <= rd_d;
      rdy_q       <= rdy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule

// File: tb/tb_id_hazard_tracker.sv
// Directed bench for id_hazard_tracker (FLUSH_AGE=1), hand-computed expectations.
module tb_id_hazard_tracker;
  localparam int XLEN = 32, NSRC = 2, NSTAGE = 3, AGE_W = 2, CNT_W = 32;

  logic                   clk, rst_n;
  logic                   issue_valid, issue_wr, hold, flush;
  logic [4:0]             issue_rd;
  logic [AGE_W-1:0]       issue_lat;
  logic [NSRC*5-1:0]      src_idx;
  logic [NSRC-1:0]        src_used;
  logic [NSRC*XLEN-1:0]   rf_data;
  logic [NSTAGE*XLEN-1:0] byp_data;
  logic                   stall, issue_ack;
  logic [NSRC*AGE_W-1:0]  fwd_sel;
  logic [NSRC*XLEN-1:0]   op_data;
  logic [CNT_W-1:0]       stall_cnt;

  int n_tests = 0, n_fail = 0;

  id_hazard_tracker #(.XLEN(XLEN), .NSRC(NSRC), .NSTAGE(NSTAGE), .AGE_W(AGE_W),
                      .FLUSH_AGE(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_wr(issue_wr),
    .issue_rd(issue_rd), .issue_lat(issue_lat), .src_idx(src_idx),
    .src_used(src_used), .rf_data(rf_data), .byp_data(byp_data), .hold(hold),
    .flush(flush), .stall(stall), .issue_ack(issue_ack), .fwd_sel(fwd_sel),
    .op_data(op_data), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [AGE_W-1:0] lat);
    issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = rd; issue_lat = lat;
    src_used = '0; src_idx = '0; hold = 1'b0; flush = 1'b0;
  endtask

  task automatic consume(input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used);
    issue_valid = 1'b1; issue_wr = 1'b0; issue_rd = '0; issue_lat = '0;
    src_idx = {s1, s0}; src_used = used; hold = 1'b0; flush = 1'b0;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_wr = 1'b0; issue_rd = '0; issue_lat = '0;
    src_used = '0; src_idx = '0; hold = 1'b0; flush = 1'b0;
  endtask

  localparam logic [31:0] RF0 = 32'hAAAA_0000, RF1 = 32'hAAAA_0001;
  localparam logic [31:0] B1 = 32'h0000_1234, B2 = 32'h0000_5678, B3 = 32'h0000_9ABC;

  initial begin
    rst_n = 1'b0;
    rf_data  = {RF1, RF0};
    byp_data = {B3, B2, B1};
    consume(5'd0, 5'd0, 2'b00);
    #2;
    // Reset state.
    chk("rst_stall", stall, 0);
    chk("rst_fwd", fwd_sel, 0);
    chk("rst_op", op_data, {RF1, RF0});
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_ack", issue_ack, 1);
    rst_n = 1'b1;
    tick();

    // ALU back-to-back.
    issue(5'd5, 2'd1); #1;
    chk("alu_issue_ack", issue_ack, 1);
    tick();
    consume(5'd5, 5'd0, 2'b01); #1;
    chk("alu_stall", stall, 0);
    chk("alu_fwd", fwd_sel, 4'h1);
    chk("alu_op0", op_data[31:0], B1);
    tick();

    // Load-use.
    issue(5'd7, 2'd2); tick();
    consume(5'd0, 5'd7, 2'b10); #1;
    chk("lu_stall", stall, 1);
    chk("lu_ack", issue_ack, 0);
    chk("lu_cnt0", stall_cnt, 0);
    tick();
    chk("lu_cnt1", stall_cnt, 1);
    chk("lu_stall2", stall, 0);
    chk("lu_fwd2", fwd_sel, 4'h8);
    chk("lu_op1", op_data[63:32], B2);
    chk("lu_ack2", issue_ack, 1);
    tick();

    // Youngest wins: x3 in slots 1 and 3.
    issue(5'd3, 2'd1); tick();
    idle(); tick();
    issue(5'd3, 2'd1); tick();
    consume(5'd3, 5'd0, 2'b11); #1;
    chk("yw_fwd", fwd_sel, 4'h1);
    chk("yw_stall", stall, 0);
    chk("yw_op", op_data, {RF1, B1});
    consume(5'd0, 5'd3, 2'b01); #1;
    chk("unused_fwd", fwd_sel, 0);
    chk("unused_stall", stall, 0);
    chk("unused_op0", op_data[31:0], RF0);
    tick();
    // x0 writer with long latency must never be tracked.
    issue(5'd0, 2'd3); tick();
    consume(5'd0, 5'd0, 2'b11); #1;
    chk("x0_stall", stall, 0);
    chk("x0_fwd", fwd_sel, 0);
    tick();
    // Latency 0 behaves like 1.
    issue(5'd11, 2'd0); tick();
    consume(5'd11, 5'd0, 2'b01); #1;
    chk("lat0_stall", stall, 0);
    chk("lat0_fwd", fwd_sel, 4'h1);
    tick();

    // Latency 3: stalls at ages 1 and 2, forwards from age 3.
    issue(5'd12, 2'd3); tick();
    consume(5'd12, 5'd0, 2'b01); #1;
    chk("l3_stall_a1", stall, 1);
    tick();
    chk("l3_stall_a2", stall, 1);
    chk("l3_fwd_a2", fwd_sel, 4'h2);
    chk("l3_cnt2", stall_cnt, 2);
    tick();
    chk("l3_cnt3", stall_cnt, 3);
    chk("l3_stall_a3", stall, 0);
    chk("l3_fwd_a3", fwd_sel, 4'h3);
    chk("l3_op0", op_data[31:0], B3);
    tick();

    // Flush squashes x9 at age 1.
    issue(5'd9, 2'd1); tick();
    issue(5'd13, 2'd1); flush = 1'b1; #1;
    chk("fl_ack", issue_ack, 0);
    tick();
    consume(5'd9, 5'd13, 2'b11); #1;
    chk("fl_fwd", fwd_sel, 0);
    chk("fl_op", op_data, {RF1, RF0});
    chk("fl_stall", stall, 0);
    tick();

    // Hold with pending load-use hazard.
    issue(5'd7, 2'd2); tick();
    consume(5'd0, 5'd7, 2'b10); hold = 1'b1; #1;
    chk("hd_stall0", stall, 1);
    chk("hd_ack", issue_ack, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hd_stall", stall, 1);
      chk("hd_fwd", fwd_sel, 4'h4);
      chk("hd_cnt", stall_cnt, 3);
    end
    hold = 1'b0; #1;
    chk("hd_rel_stall", stall, 1);
    tick();
    chk("hd_rel_cnt", stall_cnt, 4);
    chk("hd_rel_stall2", stall, 0);
    chk("hd_rel_fwd", fwd_sel, 4'h8);
    chk("hd_rel_op1", op_data[63:32], B2);
    tick();

    // Reset mid-run with all slots valid.
    issue(5'd1, 2'd3); tick();
    issue(5'd2, 2'd3); tick();
    issue(5'd4, 2'd3); tick();
    consume(5'd4, 5'd0, 2'b01); #1;
    chk("mr_pre_stall", stall, 1);
    #1; rst_n = 1'b0; #1;
    chk("mr_stall", stall, 0);
    chk("mr_fwd", fwd_sel, 0);
    chk("mr_op", op_data, {RF1, RF0});
    chk("mr_cnt", stall_cnt, 0);
    chk("mr_ack", issue_ack, 1);
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
